alu_arbiter: RTL and testbench

Shares the single 16-bit ALU datapath (add/sub/nand, 3-bit select) between NREQ independent requesters. Accepts one operation at a time through a valid/ready request port, drives the ALU operands and select from registers, captures the result and returns it on the owning requester's response port. Sits between the issue logic of each requester (e.g. fetch-side address adder, execute stage) and the shared ALU instance.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter_rr_pick.sv | 35 +++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, arbiter states and op legality.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_NAND = 3'b010
  } alu_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_EXEC = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_t;

  // Encodings above NAND still reach the ALU (which adds) but are flagged to the requester.
  function automatic logic op_is_illegal(input logic [ALU_OP_W-1:0] op);
    return (op > ALU_NAND);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bundle of the arbiter; slave = arbiter, master = requesters + ALU.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) ();

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*ALU_OP_W-1:0] req_op;
  logic [NREQ*WIDTH-1:0]    req_a;
  logic [NREQ*WIDTH-1:0]    req_b;
  logic [NREQ-1:0]          rsp_valid;
  logic [NREQ-1:0]          rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_err;
  logic [ALU_OP_W-1:0]      alu_sel;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [WIDTH-1:0]         alu_y;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_y,
    output req_ready, rsp_valid, rsp_data, rsp_err, alu_sel, alu_a, alu_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_y,
    input  req_ready, rsp_valid, rsp_data, rsp_err, alu_sel, alu_a, alu_b
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            c;
  logic [IW-1:0] cidx;
  logic          hit;

  // Scan requesters in priority order starting at ptr; the first hit wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    cidx = '0;
    hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      c          = (int'(ptr) + k) % N;
      cidx       = c[IW-1:0];
      hit        = req[cidx] & ~any;
      gnt[cidx]  = gnt[cidx] | hit;
      idx        = hit ? cidx : idx;
      any        = any | hit;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one external ALU among NREQ requesters: accept, execute, return result to owner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [ALU_OP_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                err_q, err_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0]     req_ready_s;
  logic [NREQ-1:0]     pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state and datapath latching; req_ready is only ever raised while idle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_s = '0;
    case (state_q)
      ARB_IDLE: begin
        req_ready_s = pick_gnt;
        if (pick_any) begin
          state_d = ARB_EXEC;
          owner_d = pick_idx;
          ptr_d   = IW'((int'(pick_idx) + 32'sd1) % NREQ);
          sel_d   = bus.req_op[int'(pick_idx)*ALU_OP_W +: ALU_OP_W];
          a_d     = bus.req_a[int'(pick_idx)*WIDTH +: WIDTH];
          b_d     = bus.req_b[int'(pick_idx)*WIDTH +: WIDTH];
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_EXEC: begin
        data_d               = bus.alu_y;
        err_d                = op_is_illegal(sel_q);
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = ARB_RESP;
      end
      ARB_RESP: begin
        // Only the owner's rsp_ready can release the result.
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = ARB_IDLE;
        end else begin
          state_d = ARB_RESP;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = ARB_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      sel_q       <= 3'b000;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.alu_sel   = sel_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Random and directed stimulus for alu_arbiter (NREQ=4) against a transaction-level model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] valid_v;
  logic [N-1:0] rdy_v;
  logic [2:0]   op_v [N];
  logic [W-1:0] a_v  [N];
  logic [W-1:0] b_v  [N];

  // reference model: busy flag, cycles since accept, owner, pointer, latched operation
  bit           m_busy;
  int           m_age;
  int           m_owner;
  int           m_ptr;
  logic [2:0]   m_op;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  int           grant_log [$];

  alu_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b001:  return a - b;
      3'b010:  return ~(a & b);
      default: return a + b;
    endcase
  endfunction

  // the shared ALU sitting beside the arbiter
  always_comb bus.alu_y = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    bus.req_valid = valid_v;
    bus.rsp_ready = rdy_v;
    for (int k = 0; k < N; k++) begin
      bus.req_op[3*k +: 3] = op_v[k];
      bus.req_a[W*k +: W]  = a_v[k];
      bus.req_b[W*k +: W]  = b_v[k];
    end
  endtask

  task automatic clear_inputs();
    valid_v = '0;
    rdy_v   = '0;
    for (int k = 0; k < N; k++) begin
      op_v[k] = 3'b000;
      a_v[k]  = '0;
      b_v[k]  = '0;
    end
    apply();
  endtask

  // one clock: check outputs against the model, then advance the model at the edge
  task automatic step();
    int           win;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    apply();
    #1;
    win     = -1;
    exp_rdy = '0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (win < 0 && valid_v[c]) win = c;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    exp_rv = '0;
    if (m_busy && m_age >= 1) exp_rv[m_owner] = 1'b1;
    check("req_ready", bus.req_ready, exp_rdy);
    check("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_rv != '0) begin
      check("rsp_data", bus.rsp_data, alu_ref(m_op, m_a, m_b));
      check("rsp_err", bus.rsp_err, m_op > 3'd2);
    end
    check("alu_sel", bus.alu_sel, m_op);
    check("alu_a", bus.alu_a, m_a);
    check("alu_b", bus.alu_b, m_b);
    @(posedge clk);
    if (!m_busy) begin
      if (win >= 0) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_owner = win;
        m_op    = op_v[win];
        m_a     = a_v[win];
        m_b     = b_v[win];
        m_ptr   = (win + 1) % N;
        grant_log.push_back(win);
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rdy_v[m_owner]) begin
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    clear_inputs();
    m_busy = 1'b0; m_age = 0; m_owner = 0; m_ptr = 0;
    m_op = 3'b000; m_a = '0; m_b = '0;
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_alu", {bus.alu_sel, bus.alu_a, bus.alu_b}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    valid_v = '0;
    rdy_v   = '1;
    for (int i = 0; i < 4; i++) step();
    rdy_v = '0;
  endtask

  task automatic directed(input int r, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] y, input logic err);
    int n;
    clear_inputs();
    valid_v[r] = 1'b1;
    op_v[r] = op; a_v[r] = a; b_v[r] = b;
    step();
    valid_v = '0;
    n = 0;
    while (bus.rsp_valid[r] !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("latency", n, 1);
    #1;
    check("d_data", bus.rsp_data, y);
    check("d_err", bus.rsp_err, err);
    rdy_v[r] = 1'b1;
    step();
    rdy_v = '0;
  endtask

  initial begin
    reset_now();

    // single operations, including wrap and an illegal op
    directed(0, 3'b000, 16'h1234, 16'h0001, 16'h1235, 1'b0);
    directed(1, 3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
    directed(2, 3'b010, 16'hFF00, 16'h0F0F, 16'hF0FF, 1'b0);
    directed(3, 3'b101, 16'h0002, 16'h0003, 16'h0005, 1'b1);

    // contention between req0 and req1 from a fresh pointer
    reset_now();
    grant_log.delete();
    valid_v = 4'b0011; rdy_v = '1;
    op_v[0] = 3'b000; a_v[0] = 16'h0010; b_v[0] = 16'h0001;
    op_v[1] = 3'b001; a_v[1] = 16'h0010; b_v[1] = 16'h0001;
    for (int i = 0; i < 12; i++) step();
    check("cont_cnt", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      check("cont_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]}, 16'h0101);
    end
    drain();

    // pointer at 2 after two operations, then everyone requests
    reset_now();
    directed(0, 3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    directed(1, 3'b000, 16'h0002, 16'h0002, 16'h0004, 1'b0);
    grant_log.delete();
    valid_v = '1; rdy_v = '1;
    for (int i = 0; i < 12; i++) step();
    check("rr_cnt", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      check("rr_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]}, 16'h2301);
    end
    drain();

    // backpressure on owner 1 while others request and rsp_ready[0] toggles
    clear_inputs();
    valid_v[1] = 1'b1; op_v[1] = 3'b001; a_v[1] = 16'h0100; b_v[1] = 16'h0001;
    step();
    valid_v = '1;
    for (int i = 0; i < 7; i++) begin
      rdy_v[0] = i[0];
      rdy_v[1] = 1'b0;
      step();
    end
    check("bp_owner", bus.rsp_valid, 4'b0010);
    check("bp_data", bus.rsp_data, 16'h00FF);
    drain();

    // reset while an operation is in EXEC
    clear_inputs();
    valid_v[2] = 1'b1; op_v[2] = 3'b000; a_v[2] = 16'h0005; b_v[2] = 16'h0006;
    step();
    valid_v = '0;
    apply();
    #2;
    reset_now();
    grant_log.delete();
    valid_v = '1; rdy_v = '1;
    step();
    check("post_rst_grant_cnt", grant_log.size(), 1);
    if (grant_log.size() >= 1) check("post_rst_grant", grant_log[0], 0);
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      valid_v = N'($urandom);
      rdy_v   = N'($urandom);
      for (int k = 0; k < N; k++) begin
        op_v[k] = 3'($urandom_range(0, 7));
        a_v[k]  = W'($urandom);
        b_v[k]  = W'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
